// File: rtl/mac_seq.sv
// mac_seq: operand sequencer for a two-stage MAC, one dot product per vec_len pairs.
// Define MAC_SEQ_PROD_EN to add prod_mode (running product of in_a).
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
module mac_seq #(
  parameter int LEN_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [`DATA_WIDTH-1:0] in_a,
  input  logic [`DATA_WIDTH-1:0] in_b,
  input  logic [LEN_W-1:0]       vec_len,
`ifdef MAC_SEQ_PROD_EN
  input  logic                   prod_mode,
`endif
  output logic [`DATA_WIDTH-1:0] data_0,
  output logic [`DATA_WIDTH-1:0] data_1,
  output logic                   mulsel,
  output logic                   addsel,
  input  logic [`DATA_WIDTH-1:0] mac_in,
  output logic [`DATA_WIDTH-1:0] res_data,
  output logic                   res_valid,
  input  logic                   res_ready
);
  localparam int DW = `DATA_WIDTH;
  logic [LEN_W-1:0] cnt, len_q, len_cur;
  logic first, last, take;
  logic v0, f0, l0, v1, f1, l1, v2, l2;
  logic [DW-1:0] nxt_0, nxt_1;
  logic nxt_m;
  always_comb begin
    first = cnt == '0;
    len_cur = first ? (vec_len == '0 ? LEN_W'(1) : vec_len) : len_q;
    last = cnt + LEN_W'(1) == len_cur;
    // only one vector end may be in flight or held at a time
    in_ready = !rst && !(last && (res_valid || l0 || l1 || l2));
    take = in_valid && in_ready;
  end
`ifdef MAC_SEQ_PROD_EN
  logic mode_q, mode_cur, p0, p1;
  always_comb begin
    mode_cur = first ? prod_mode : mode_q;
    nxt_0 = take ? in_a : (mode_q ? DW'(1) : '0);
    nxt_1 = take ? (mode_cur && first ? DW'(1) : in_b) : '0;
    nxt_m = take ? mode_cur && !first : mode_q;
    addsel = !rst && !p1 && !(v1 && f1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= 1'b0;
      p0 <= 1'b0;
      p1 <= 1'b0;
    end else begin
      if (take && first) mode_q <= prod_mode;
      p0 <= take ? mode_cur : mode_q;
      p1 <= p0;
    end
  end
`else
  always_comb begin
    nxt_0 = take ? in_a : '0;
    nxt_1 = take ? in_b : '0;
    nxt_m = 1'b0;
    addsel = !rst && !(v1 && f1);
  end
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      data_0 <= '0;
      data_1 <= '0;
      mulsel <= 1'b0;
      cnt <= '0;
      len_q <= '0;
      {v0, f0, l0, v1, f1, l1, v2, l2} <= '0;
      res_data <= '0;
      res_valid <= 1'b0;
    end else begin
      data_0 <= nxt_0;
      data_1 <= nxt_1;
      mulsel <= nxt_m;
      {v0, f0, l0} <= {take, take && first, take && last};
      {v1, f1, l1} <= {v0, f0, l0};
      {v2, l2} <= {v1, l1};
      if (take) cnt <= last ? '0 : cnt + LEN_W'(1);
      if (take && first) len_q <= len_cur;
      if (v2 && l2) begin
        res_data <= mac_in;
        res_valid <= 1'b1;
      end else if (res_ready) res_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mac_seq.sv
// tb_mac_seq: directed checks of mac_seq driving a behavioural two-stage MAC.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
module tb_mac_seq;
  localparam int DW = `DATA_WIDTH;
  logic clk = 0, rst = 1, in_valid = 0, res_ready = 0, prod_mode = 0;
  logic in_ready, mulsel, addsel, res_valid;
  logic [DW-1:0] in_a = 0, in_b = 0, data_0, data_1, res_data;
  logic [7:0] vec_len = 0;
  logic [DW-1:0] mult = 0, mac = 0;
  int vectors = 0, miscompares = 0;

  mac_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .vec_len(vec_len),
`ifdef MAC_SEQ_PROD_EN
    .prod_mode(prod_mode),
`endif
    .data_0(data_0), .data_1(data_1), .mulsel(mulsel), .addsel(addsel),
    .mac_in(mac), .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready)
  );

  always #5 clk = ~clk;

  // external MAC: mulsel feeds the product back, addsel accumulates
  always_ff @(posedge clk) begin
    mult <= data_0 * (mulsel ? mult : data_1);
    mac <= addsel ? mac + mult : mult;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [7:0] len);
    int n = 0;
    in_valid = 1; in_a = a; in_b = b; vec_len = len;
    while (!in_ready && n < 50) begin tick(); n++; end
    if (n == 50) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout: in_ready stuck at %0b, required 1", in_ready);
    end
    tick();
    in_valid = 0;
  endtask

  task automatic expect_res(input string name, input logic [DW-1:0] exp);
    int n = 0;
    while (!res_valid && n < 20) begin tick(); n++; end
    vectors++;
    if (res_valid !== 1'b1 || res_data !== exp) begin
      miscompares++;
      $display("FAIL %s: res_valid=%0b res_data=%0d, required 1/%0d", name, res_valid, res_data, exp);
    end
    res_ready = 1; tick(); res_ready = 0;
  endtask

  task automatic test_reset();
    rst = 1; tick(); tick();
    vectors += 7;
    if (data_0 !== 0) begin miscompares++; $display("FAIL rst_data_0: got %0d required 0", data_0); end
    if (data_1 !== 0) begin miscompares++; $display("FAIL rst_data_1: got %0d required 0", data_1); end
    if (mulsel !== 0) begin miscompares++; $display("FAIL rst_mulsel: got %0b required 0", mulsel); end
    if (addsel !== 0) begin miscompares++; $display("FAIL rst_addsel: got %0b required 0", addsel); end
    if (res_data !== 0) begin miscompares++; $display("FAIL rst_res_data: got %0d required 0", res_data); end
    if (res_valid !== 0) begin miscompares++; $display("FAIL rst_res_valid: got %0b required 0", res_valid); end
    if (in_ready !== 0) begin miscompares++; $display("FAIL rst_in_ready: got %0b required 0", in_ready); end
    rst = 0; tick();
    vectors++;
    if (in_ready !== 1) begin miscompares++; $display("FAIL post_rst_in_ready: got %0b required 1", in_ready); end
  endtask

  task automatic test_back_to_back();
    send(1, 2, 3); send(3, 4, 3); send(5, 6, 3);
    tick(); tick();
    vectors++;
    if (res_valid !== 0) begin miscompares++; $display("FAIL b2b_early: res_valid=%0b required 0", res_valid); end
    tick();
    vectors++;
    if (res_valid !== 1 || res_data !== 44) begin
      miscompares++; $display("FAIL b2b_latency: res_valid=%0b res_data=%0d required 1/44", res_valid, res_data);
    end
    res_ready = 1; tick(); res_ready = 0;
  endtask

  task automatic test_bubbles();
    send(1, 2, 3);
    tick();
    vectors++;
    if (addsel !== 0) begin miscompares++; $display("FAIL bub_first_addsel: got %0b required 0", addsel); end
    tick();
    vectors++;
    if (addsel !== 1) begin miscompares++; $display("FAIL bub_addsel: got %0b required 1", addsel); end
    send(3, 4, 3);
    tick(); tick();
    send(5, 6, 3);
    expect_res("bubbles", 44);
  endtask

  task automatic test_hold();
    int early = 0;
    send(2, 3, 2); send(4, 5, 2); send(1, 1, 2);
    in_valid = 1; in_a = 1; in_b = 1;
    for (int i = 0; i < 10; i++) begin
      if (in_ready) early++;
      tick();
    end
    vectors += 3;
    if (early != 0) begin miscompares++; $display("FAIL hold_stall: in_ready high %0d cycles, required 0", early); end
    if (res_valid !== 1 || res_data !== 26) begin
      miscompares++; $display("FAIL hold_res: res_valid=%0b res_data=%0d required 1/26", res_valid, res_data);
    end
    res_ready = 1; tick(); res_ready = 0;
    if (in_ready !== 1) begin miscompares++; $display("FAIL hold_release: in_ready=%0b required 1", in_ready); end
    tick();
    in_valid = 0;
    expect_res("hold_second", 2);
  endtask

  task automatic test_len_wrap();
    send(7, 9, 0);
    expect_res("len_zero", 63);
    send(200, 2, 2); send(100, 1, 2);
    expect_res("wrap", 244);
  endtask

  task automatic test_mid_reset();
    send(1, 1, 4); send(2, 2, 4);
    rst = 1; tick();
    vectors++;
    if (in_ready !== 0) begin miscompares++; $display("FAIL midrst_in_ready: got %0b required 0", in_ready); end
    rst = 0;
    for (int i = 0; i < 5; i++) tick();
    vectors++;
    if (res_valid !== 0) begin miscompares++; $display("FAIL midrst_stale: res_valid=%0b required 0", res_valid); end
    send(3, 3, 1);
    expect_res("midrst_fresh", 9);
  endtask

`ifdef MAC_SEQ_PROD_EN
  task automatic test_prod();
    prod_mode = 1;
    send(2, 9, 3);
    tick();
    send(3, 7, 3); send(4, 5, 3);
    prod_mode = 0;
    expect_res("prod", 24);
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_bubbles();
    test_hold();
    test_len_wrap();
    test_mid_reset();
`ifdef MAC_SEQ_PROD_EN
    test_prod();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
